bcd_counter: RTL and testbench
==============================

Name: bcd_counter

Overview:
- Registered, multi-digit packed-BCD up/down counter, parametrised in digit count.
- Supports synchronous load, count enable, direction select, and selectable wrap or saturate at the decimal limits.
- Produces one-cycle rollover and load-error pulses.
- Used wherever the design needs a decimal event counter: scoreboards, timers, and display drivers feeding seven-segment decoders.

Parameters:
- DIGITS, 3, number of BCD digits; count width is 4*DIGITS bits; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- sat_mode  input  1  1 = saturate at limits, 0 = wrap around.
- load  input  1  synchronous load strobe; has priority over en.
- load_val  input  4*DIGITS  packed BCD value to load; digit 0 in bits [3:0].
- count  output  4*DIGITS  current packed BCD count, registered.
- rollover  output  1  registered one-cycle pulse when the count wraps.
- load_err  output  1  registered one-cycle pulse when load_val held a non-BCD digit.
- at_max  output  1  combinational; 1 when every digit of count is 9.
- at_min  output  1  combinational; 1 when count is 0.

Behaviour:
- Reset (asynchronous, rst=1): count=0, rollover=0, load_err=0. So at_min=1 and at_max=0. Reset may assert mid-operation and overrides all inputs immediately. The first update is on the first rising clk after rst deasserts.
- Priority each cycle: load > en > hold. rollover and load_err are 0 in every cycle unless set by the rules below.
- Load (load=1):
  - Next count = load_val digit by digit.
  - Any digit >9 (A..F) is replaced by 9 in the loaded value.
  - load_err=1 for the next cycle if any digit was replaced.
  - en, up and sat_mode are ignored; rollover=0.
- Increment (load=0, en=1, up=1):
  - Digit 0 increases by 1.
  - A digit at 9 becomes 0 and carries into the next digit; the ripple runs through all DIGITS in one cycle.
  - Result is visible on count one cycle after the enabled edge.
- Decrement (load=0, en=1, up=0):
  - Digit 0 decreases by 1.
  - A digit at 0 becomes 9 and borrows from the next digit.
- Upper limit (all 9s, incrementing):
  - sat_mode=0: count becomes 0 and rollover=1 next cycle.
  - sat_mode=1: count holds at all 9s and rollover=0.
- Lower limit (0, decrementing):
  - sat_mode=0: count becomes all 9s and rollover=1.
  - sat_mode=1: count holds at 0 and rollover=0.
- Mode and direction may change on any cycle. They take effect on the same edge they are sampled; there is no pipeline.
- Hold (load=0, en=0): count unchanged.
- Invariant: count never contains a digit >9, under any input sequence.
- Combinational path depth is linear in DIGITS. Arithmetic is per-digit 4-bit only; the counter never adds in binary across digit boundaries.

Test Plan:
- DIGITS=3. Reset asserted asynchronously mid-count at 0x457 -> count=0x000 immediately, without a clk edge; at_min=1, rollover=0, load_err=0.
- Load 0x098, then en=1, up=1 for 3 cycles -> count 0x099, 0x100, 0x101; rollover stays 0.
- Load 0x999 with en=1, up=1, sat_mode=0 -> next cycle count=0x000 with rollover=1 for exactly one cycle. Repeat with sat_mode=1 -> count stays 0x999, rollover=0, at_max=1.
- Load 0x000, en=1, up=0, sat_mode=0 -> count=0x999, rollover=1. Same with sat_mode=1 -> count stays 0x000, at_min=1.
- Load 0x1A3 -> count=0x193, load_err=1 for one cycle. Load and en asserted together -> load wins, and no count step occurs that cycle.
- Random en, up, sat_mode, load and load_val over 10k cycles, checked against a decimal reference model -> count always legal BCD and equal to the model.

Source files
------------

// File: rtl/bcd_counter.sv
// Multi-digit packed-BCD up/down counter with synchronous load, wrap or
// saturate at the decimal limits, and one-cycle rollover / load-error pulses.
module bcd_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat_mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  rollover,
  output logic                  load_err,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] count_q, count_d;
  logic         rollover_q, rollover_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] step_val;
  logic         carry_out;
  logic [W-1:0] load_clamped;
  logic         load_bad;

  // Clamp a non-decimal nibble (A..F) to 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One decimal digit step: returns {carry/borrow out, new digit}.
  function automatic logic [4:0] step_digit(input logic [3:0] d,
                                            input logic       inc,
                                            input logic       cin);
    if (!cin)
      return {1'b0, d};
    if (inc)
      return (d == 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    return (d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1};
  endfunction

  // Digit-serial ripple; carry_out set means the counter crossed a decimal limit.
  always_comb begin
    logic       c;
    logic [4:0] r;
    step_val = '0;
    c        = 1'b1;
    r        = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r                  = step_digit(count_q[4*i +: 4], up, c);
      step_val[4*i +: 4] = r[3:0];
      c                  = r[4];
    end
    carry_out = c;
  end

  always_comb begin
    load_clamped = '0;
    load_bad     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
      if (load_val[4*i +: 4] > 4'd9)
        load_bad = 1'b1;
    end
  end

  always_comb begin
    count_d    = count_q;
    rollover_d = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = load_clamped;
      load_err_d = load_bad;
    end else if (en) begin
      if (!carry_out) begin
        count_d = step_val;
      end else if (!sat_mode) begin
        count_d    = step_val;
        rollover_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign rollover = rollover_q;
  assign load_err = load_err_q;
  assign at_max   = (count_q == ALL_NINES);
  assign at_min   = (count_q == '0);

endmodule

// File: tb/tb_bcd_counter.sv
// Scoreboard bench for bcd_counter: stimulus pushes decimal-model predictions,
// a monitor pops and compares one entry per clock after each rising edge.
module tb_bcd_counter;

  localparam int D   = 3;
  localparam int W   = 4 * D;
  localparam int MAX = 999;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, up = 1'b0, sat_mode = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         rollover, load_err, at_max, at_min;

  bcd_counter #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count),
    .rollover(rollover), .load_err(load_err), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   val;
    logic ro;
    logic le;
  } exp_t;

  exp_t q[$];
  int   model_v = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and predict the registered outputs after the edge.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic e,
                      input logic u, input logic s);
    exp_t x;
    int   nv;
    logic bad;
    @(negedge clk);
    load = ld; load_val = lv; en = e; up = u; sat_mode = s;
    x.ro = 1'b0;
    x.le = 1'b0;
    if (ld) begin
      nv  = 0;
      bad = 1'b0;
      for (int i = D - 1; i >= 0; i--) begin
        int dg;
        dg = int'(lv[4*i +: 4]);
        if (dg > 9) begin
          dg  = 9;
          bad = 1'b1;
        end
        nv = nv * 10 + dg;
      end
      model_v = nv;
      x.le    = bad;
    end else if (e) begin
      if (u) begin
        if (model_v < MAX) model_v = model_v + 1;
        else if (!s) begin model_v = 0; x.ro = 1'b1; end
      end else begin
        if (model_v > 0) model_v = model_v - 1;
        else if (!s) begin model_v = MAX; x.ro = 1'b1; end
      end
    end
    x.val = model_v;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      logic legal;
      x = q.pop_front();
      legal = 1'b1;
      for (int i = 0; i < D; i++)
        if (count[4*i +: 4] > 4'd9) legal = 1'b0;
      chk("count",    32'(count),    32'(to_bcd(x.val)));
      chk("rollover", 32'(rollover), 32'(x.ro));
      chk("load_err", 32'(load_err), 32'(x.le));
      chk("at_max",   32'(at_max),   32'(x.val == MAX));
      chk("at_min",   32'(at_min),   32'(x.val == 0));
      chk("bcd_legal", 32'(legal),   32'd1);
    end
  end

  initial begin
    #12;
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_at_min",   32'(at_min),   32'h1);
    chk("rst_at_max",   32'(at_max),   32'h0);
    chk("rst_rollover", 32'(rollover), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a cycle while holding 0x457.
    step(1'b1, 12'h457, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    load = 1'b0; en = 1'b1; up = 1'b1;
    rst  = 1'b1;
    #1;
    chk("async_rst_count",    32'(count),    32'h0);
    chk("async_rst_at_min",   32'(at_min),   32'h1);
    chk("async_rst_rollover", 32'(rollover), 32'h0);
    chk("async_rst_load_err", 32'(load_err), 32'h0);
    en = 1'b0;
    model_v = 0;
    @(negedge clk);
    rst = 1'b0;

    // Ripple carry across digits.
    step(1'b1, 12'h098, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);

    // Upper limit: wrap then saturate (load wins over en on the load cycle).
    step(1'b1, 12'h999, 1'b1, 1'b1, 1'b0);
    step(1'b0, 12'h0,   1'b1, 1'b1, 1'b0);
    step(1'b0, 12'h0,   1'b0, 1'b1, 1'b0);
    step(1'b1, 12'h999, 1'b1, 1'b1, 1'b1);
    step(1'b0, 12'h0,   1'b1, 1'b1, 1'b1);
    step(1'b0, 12'h0,   1'b0, 1'b1, 1'b1);

    // Lower limit: wrap then saturate.
    step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 12'h0,   1'b1, 1'b0, 1'b0);
    step(1'b0, 12'h0,   1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 12'h0,   1'b1, 1'b0, 1'b1);
    step(1'b0, 12'h0,   1'b0, 1'b0, 1'b1);

    // Non-BCD load clamps to 9 and flags; load and en together.
    step(1'b1, 12'h1A3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 12'h0,   1'b0, 1'b1, 1'b0);
    step(1'b1, 12'h050, 1'b1, 1'b1, 1'b0);
    step(1'b0, 12'h0,   1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 10000; n++) begin
      logic [W-1:0] lv;
      case ($urandom_range(0, 3))
        0:       lv = 12'h999;
        1:       lv = 12'h000;
        default: lv = W'($urandom);
      endcase
      step(($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom));
    end
    step(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
